// File: rtl/chunk_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// chunk_scheduler_pkg : scheduler state encodings, bank ids, default sizes
// Rev 1.0
// ============================================================================
package chunk_scheduler_pkg;

  localparam int DEFAULT_SAMPLE_SIZE  = 24;
  localparam int DEFAULT_IO_BUFF_SIZE = 64;

  localparam logic BANK_0 = 1'b0;
  localparam logic BANK_1 = 1'b1;

  typedef enum logic [1:0] {
    SCHED_IDLE = 2'd0,
    SCHED_FILL = 2'd1,
    SCHED_RUN  = 2'd2
  } sched_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/chunk_ptr_counter.sv
`default_nettype none
// ============================================================================
// chunk_ptr_counter : in-bank address counter, wraps at 2**WIDTH, flags last
// Rev 1.0
// ============================================================================
module chunk_ptr_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc)
      count <= count + 1'b1;
  end

  assign last = &count;

endmodule
`default_nettype wire

// File: rtl/chunk_scheduler.sv
`default_nettype none
// ============================================================================
// chunk_scheduler : double-buffer capture/process/playback sequencer
// Rev 1.0
// ============================================================================
module chunk_scheduler
  import chunk_scheduler_pkg::*;
#(
  parameter int SAMPLE_SIZE      = DEFAULT_SAMPLE_SIZE,
  parameter int IO_BUFF_SIZE     = DEFAULT_IO_BUFF_SIZE,
  parameter int IO_BUFF_PTR_BITS = $clog2(IO_BUFF_SIZE)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        sample_strobe,
  input  logic [SAMPLE_SIZE-1:0]      sample_in,
  output logic                        cap_we,
  output logic                        cap_bank,
  output logic [IO_BUFF_PTR_BITS-1:0] cap_addr,
  output logic [SAMPLE_SIZE-1:0]      cap_data,
  output logic                        proc_bank,
  output logic                        chunk_pulse,
  input  logic                        proc_done,
  output logic [IO_BUFF_PTR_BITS-1:0] play_addr,
  input  logic [SAMPLE_SIZE-1:0]      play_data,
  output logic [SAMPLE_SIZE-1:0]      sample_out,
  output logic                        overrun,
  input  logic                        clr_overrun,
  output logic [7:0]                  overrun_cnt
);

  sched_state_t r_state, w_state_next;

  logic                        w_cap, w_play, w_swap, w_overrun, w_pulse;
  logic                        w_clr;
  logic [IO_BUFF_PTR_BITS-1:0] w_wr_ptr, w_rd_ptr;
  logic                        w_wr_last, w_rd_last;
  logic                        r_bank, r_busy, r_mute;

  assign w_clr = ~enable;

  chunk_ptr_counter #(.WIDTH(IO_BUFF_PTR_BITS)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_cap),
    .clr   (w_clr),
    .count (w_wr_ptr),
    .last  (w_wr_last)
  );

  // Playback restarts at every swap so it stays aligned with the new play bank.
  chunk_ptr_counter #(.WIDTH(IO_BUFF_PTR_BITS)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_play),
    .clr   (w_clr | w_swap),
    .count (w_rd_ptr),
    .last  (w_rd_last)
  );

  assign play_addr = w_rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= SCHED_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_cap        = 1'b0;
    w_play       = 1'b0;
    if (!enable) begin
      w_state_next = SCHED_IDLE;
    end else begin
      case (r_state)
        SCHED_IDLE: w_state_next = SCHED_FILL;
        SCHED_FILL: begin
          w_cap = sample_strobe;
          if (sample_strobe && w_wr_last)
            w_state_next = SCHED_RUN;
        end
        SCHED_RUN: begin
          w_cap  = sample_strobe;
          w_play = sample_strobe;
        end
        default: w_state_next = SCHED_IDLE;
      endcase
    end
  end

  // A done pulse landing on the swap cycle frees the processor in time.
  assign w_swap    = w_cap & w_wr_last;
  assign w_overrun = w_swap & r_busy & ~proc_done;
  assign w_pulse   = w_swap & ~w_overrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_we      <= 1'b0;
      cap_addr    <= '0;
      cap_data    <= '0;
      cap_bank    <= BANK_0;
      r_bank      <= BANK_0;
      chunk_pulse <= 1'b0;
      sample_out  <= '0;
      r_busy      <= 1'b0;
      r_mute      <= 1'b0;
    end else if (!enable) begin
      cap_we      <= 1'b0;
      cap_addr    <= '0;
      cap_data    <= '0;
      cap_bank    <= BANK_0;
      r_bank      <= BANK_0;
      chunk_pulse <= 1'b0;
      sample_out  <= '0;
      r_busy      <= 1'b0;
      r_mute      <= 1'b0;
    end else begin
      cap_we <= w_cap;
      if (w_cap) begin
        cap_addr <= w_wr_ptr;
        cap_data <= sample_in;
      end
      // Port bank lags the internal bank so the last write of a chunk keeps its bank.
      cap_bank <= r_bank;
      if (w_swap)
        r_bank <= ~r_bank;
      chunk_pulse <= w_pulse;
      if (w_pulse)
        r_busy <= 1'b1;
      else if (proc_done)
        r_busy <= 1'b0;
      if (w_play)
        sample_out <= r_mute ? '0 : play_data;
      // Mute is per play chunk: nothing processed yet after fill, or bank still in use.
      if (w_swap && (r_state == SCHED_FILL))
        r_mute <= 1'b1;
      else if (w_play && w_rd_last)
        r_mute <= w_overrun;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      proc_bank <= BANK_0;
    else if (w_swap)
      proc_bank <= r_bank;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun     <= 1'b0;
      overrun_cnt <= 8'd0;
    end else if (w_overrun) begin
      overrun     <= 1'b1;
      overrun_cnt <= clr_overrun ? 8'd1 : sat_inc8(overrun_cnt);
    end else if (clr_overrun) begin
      overrun     <= 1'b0;
      overrun_cnt <= 8'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chunk_scheduler.sv
`default_nettype none
// ============================================================================
// tb_chunk_scheduler : chunk-level model plus directed scenario checks
// Rev 1.0
// ============================================================================
module tb_chunk_scheduler;

  localparam int SS = 24;
  localparam int N  = 4;
  localparam int PB = 2;
  localparam int PROC_DELAY = 10;

  logic          clk, rst, enable, sample_strobe, proc_done, clr_overrun;
  logic [SS-1:0] sample_in, play_data, cap_data, sample_out;
  logic [PB-1:0] cap_addr, play_addr;
  logic          cap_we, cap_bank, proc_bank, chunk_pulse, overrun;
  logic [7:0]    overrun_cnt;

  chunk_scheduler #(.SAMPLE_SIZE(SS), .IO_BUFF_SIZE(N), .IO_BUFF_PTR_BITS(PB)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_strobe(sample_strobe),
    .sample_in(sample_in), .cap_we(cap_we), .cap_bank(cap_bank), .cap_addr(cap_addr),
    .cap_data(cap_data), .proc_bank(proc_bank), .chunk_pulse(chunk_pulse),
    .proc_done(proc_done), .play_addr(play_addr), .play_data(play_data),
    .sample_out(sample_out), .overrun(overrun), .clr_overrun(clr_overrun),
    .overrun_cnt(overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;
  int pulse_cnt = 0;
  int proc_mode = 0;  // 0: done after delay, 1: withhold, 2: done with next strobe

  logic [SS-1:0] ram [0:1][0:N-1];

  always @(posedge clk) play_data <= ram[~proc_bank][play_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: samples counted since enable; chunk number and index derive everything.
  bit            m_en, m_busy, m_mute, m_proc_bank, m_ovr;
  int            m_count, m_cnt;
  bit            e_we, e_bank, e_pulse;
  int            e_addr;
  logic [SS-1:0] e_data, e_out;

  initial begin
    int idx, cc;
    bit sw, ovr, pl;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_en = 0; m_busy = 0; m_mute = 0; m_proc_bank = 0; m_ovr = 0;
        m_count = 0; m_cnt = 0;
        e_we = 0; e_bank = 0; e_pulse = 0; e_addr = 0; e_data = '0; e_out = '0;
      end else begin
        e_we = 0; e_pulse = 0; ovr = 0;
        if (!enable) begin
          m_en = 0; m_count = 0; m_busy = 0; m_mute = 0; e_out = '0;
        end else if (!m_en) begin
          m_en = 1;
        end else begin
          idx = m_count % N;
          cc  = m_count / N;
          sw  = sample_strobe && (idx == N - 1);
          ovr = sw && m_busy && !proc_done;
          pl  = sw && !ovr;
          if (sample_strobe) begin
            e_we = 1; e_addr = idx; e_data = sample_in; e_bank = cc[0];
            if (cc >= 1) e_out = m_mute ? '0 : ram[cc % 2][idx];
            m_count++;
          end
          if (pl) m_busy = 1;
          else if (proc_done) m_busy = 0;
          if (sw) begin
            m_proc_bank = cc[0];
            m_mute = (cc == 0) || ovr;
            e_pulse = pl;
          end
        end
        if (ovr) begin
          m_ovr = 1;
          m_cnt = clr_overrun ? 1 : ((m_cnt == 255) ? 255 : m_cnt + 1);
        end else if (clr_overrun) begin
          m_ovr = 0; m_cnt = 0;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chunk_pulse === 1'b1) pulse_cnt++;
      if (chk_en && !rst) begin
        chk("cap_we", {31'd0, cap_we}, {31'd0, e_we});
        if (e_we) begin
          chk("cap_addr", {30'd0, cap_addr}, e_addr);
          chk("cap_data", {8'd0, cap_data}, {8'd0, e_data});
          chk("cap_bank", {31'd0, cap_bank}, {31'd0, e_bank});
        end
        chk("chunk_pulse", {31'd0, chunk_pulse}, {31'd0, e_pulse});
        chk("sample_out", {8'd0, sample_out}, {8'd0, e_out});
        chk("proc_bank", {31'd0, proc_bank}, {31'd0, m_proc_bank});
        chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        chk("overrun_cnt", {24'd0, overrun_cnt}, m_cnt);
      end
    end
  end

  // Processor stand-in.
  initial begin
    bit pend;
    int cd;
    pend = 0; cd = 0; proc_done = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      proc_done = 1'b0;
      if (rst) begin
        pend = 0; cd = 0;
      end else if (chunk_pulse) begin
        pend = 1; cd = PROC_DELAY;
      end else if (pend) begin
        if (cd > 0) cd--;
        if ((proc_mode == 0 && cd == 0) || (proc_mode == 2 && sample_strobe)) begin
          proc_done = 1'b1;
          pend = 0;
        end
      end
    end
  end

  logic          snap_we, snap_bank, snap_pulse;
  logic [PB-1:0] snap_addr;
  logic [SS-1:0] snap_data, snap_out;

  task automatic do_strobe(input logic [SS-1:0] s);
    @(negedge clk);
    sample_strobe = 1'b1;
    sample_in = s;
    @(negedge clk);
    sample_strobe = 1'b0;
    snap_we = cap_we; snap_bank = cap_bank; snap_pulse = chunk_pulse;
    snap_addr = cap_addr; snap_data = cap_data; snap_out = sample_out;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, {31'd0, cap_we}, 32'd0);
    chk({tag, "_cap_bank"}, {31'd0, cap_bank}, 32'd0);
    chk({tag, "_cap_addr"}, {30'd0, cap_addr}, 32'd0);
    chk({tag, "_pulse"}, {31'd0, chunk_pulse}, 32'd0);
    chk({tag, "_proc_bank"}, {31'd0, proc_bank}, 32'd0);
    chk({tag, "_play_addr"}, {30'd0, play_addr}, 32'd0);
    chk({tag, "_sample_out"}, {8'd0, sample_out}, 32'd0);
    chk({tag, "_overrun_cnt"}, {24'd0, overrun_cnt}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; sample_strobe = 1'b0; sample_in = '0; clr_overrun = 1'b0;
    for (int i = 0; i < N; i++) begin
      ram[0][i] = 24'hA0 + 24'(i);
      ram[1][i] = 24'hB0 + 24'(i);
    end
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    chk_en = 1;
    repeat (2) @(negedge clk);

    // Fill to run
    enable = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      do_strobe(24'(i));
      if (i == 1) begin
        chk("fill_first_we", {31'd0, snap_we}, 32'd1);
        chk("fill_first_addr", {30'd0, snap_addr}, 32'd0);
        chk("fill_first_data", {8'd0, snap_data}, 32'd1);
      end
    end
    chk("fill_last_pulse", {31'd0, snap_pulse}, 32'd1);
    chk("fill_last_addr", {30'd0, snap_addr}, 32'd3);
    chk("fill_last_bank", {31'd0, snap_bank}, 32'd0);
    chk("fill_pulse_count", pulse_cnt, 32'd1);
    chk("fill_cap_bank", {31'd0, cap_bank}, 32'd1);
    chk("fill_proc_bank", {31'd0, proc_bank}, 32'd0);

    // Steady state: first run chunk muted, then bank 0 contents
    for (int i = 5; i <= 8; i++) begin
      do_strobe(24'(i));
      chk("run1_muted", {8'd0, snap_out}, 32'd0);
    end
    for (int i = 9; i <= 12; i++) begin
      do_strobe(24'(i));
      chk("run2_play", {8'd0, snap_out}, 32'hA0 + 32'(i - 9));
    end
    chk("steady_overrun", {31'd0, overrun}, 32'd0);

    // Overrun: processor withholds done across the next swap
    proc_mode = 1;
    for (int i = 13; i <= 16; i++) do_strobe(24'(i));
    chk("ovr_no_pulse", {31'd0, snap_pulse}, 32'd0);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    chk("ovr_cnt", {24'd0, overrun_cnt}, 32'd1);
    do_strobe(24'd17);
    chk("ovr_muted", {8'd0, snap_out}, 32'd0);
    do_strobe(24'd18);
    @(negedge clk);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    chk("clr_flag", {31'd0, overrun}, 32'd0);
    chk("clr_cnt", {24'd0, overrun_cnt}, 32'd0);
    do_strobe(24'd19);
    chk("ovr_muted_late", {8'd0, snap_out}, 32'd0);

    // Done coincident with swap
    proc_mode = 2;
    do_strobe(24'd20);
    proc_mode = 0;
    chk("coinc_pulse", {31'd0, snap_pulse}, 32'd1);
    chk("coinc_overrun", {31'd0, overrun}, 32'd0);
    do_strobe(24'd21);
    chk("coinc_unmuted", {8'd0, snap_out}, 32'hB0);
    for (int i = 22; i <= 24; i++) do_strobe(24'(i));

    // Async reset mid-chunk
    do_strobe(24'd25);
    do_strobe(24'd26);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    do_strobe(24'h31);
    chk("post_rst_addr", {30'd0, snap_addr}, 32'd0);
    chk("post_rst_bank", {31'd0, snap_bank}, 32'd0);
    chk("post_rst_we", {31'd0, snap_we}, 32'd1);
    do_strobe(24'h32);

    // Enable drop mid-chunk
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_addr", {30'd0, play_addr}, 32'd0);
    do_strobe(24'h33);
    chk("dis_no_we", {31'd0, snap_we}, 32'd0);
    chk("dis_out", {8'd0, snap_out}, 32'd0);
    enable = 1'b1;
    @(negedge clk);
    do_strobe(24'h34);
    chk("reen_addr", {30'd0, snap_addr}, 32'd0);
    chk("reen_data", {8'd0, snap_data}, 32'h34);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
